// File: rtl/flag_gen.sv
// Condition-flag generator: saturating ADD/SUB result plus registered {N,V,Z} flags
// with a written-mask and a two-state validity FSM for the branch/PC stage.
module flag_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stall,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] sat_res,
    output logic [2:0]       F,
    output logic             flags_valid,
    output logic             state_o,
    output logic [2:0]       wmask_o
);

    typedef enum logic {
        UNDEF = 1'b0,
        VALID = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    state_e           state_q;
    logic [2:0]       f_q;
    logic [2:0]       mask_q;
    logic             flags_valid_q;

    logic [WIDTH-1:0] add_raw;
    logic [WIDTH-1:0] sub_raw;
    logic             add_ovf;
    logic             sub_ovf;
    logic             is_arith;
    logic             is_zop;
    logic             ovf;
    logic             upd;
    logic [2:0]       f_d;
    logic [2:0]       mask_d;

    // Carry-out is discarded; overflow is judged from sign bits only.
    assign add_raw  = A + B;
    assign sub_raw  = A - B;
    assign add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_raw[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_raw[WIDTH-1] != A[WIDTH-1]);
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign is_zop   = (opcode == OP_XOR) || (opcode == OP_SLL) ||
                      (opcode == OP_SRA) || (opcode == OP_ROR);
    assign ovf      = (opcode == OP_SUB) ? sub_ovf : (opcode == OP_ADD) ? add_ovf : 1'b0;
    assign upd      = en && !stall;

    always_comb begin
        sat_res = add_raw;
        if (opcode == OP_SUB) begin
            sat_res = sub_raw;
        end
        if (is_arith && ovf) begin
            sat_res = A[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        f_d    = f_q;
        mask_d = mask_q;
        if (is_arith) begin
            f_d    = {sat_res[WIDTH-1], ovf, (sat_res == '0)};
            mask_d = 3'b111;
        end else if (is_zop) begin
            f_d[0]    = (alu_res == '0);
            mask_d[0] = 1'b1;
        end
    end

    // Stall and en=0 both freeze flags, mask and FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= UNDEF;
            f_q           <= 3'b000;
            mask_q        <= 3'b000;
            flags_valid_q <= 1'b0;
        end else if (upd && (is_arith || is_zop)) begin
            f_q    <= f_d;
            mask_q <= mask_d;
            case (state_q)
                UNDEF: begin
                    state_q       <= VALID;
                    flags_valid_q <= 1'b1;
                end
                VALID: begin
                    state_q       <= VALID;
                    flags_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= UNDEF;
                    flags_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign F           = f_q;
    assign flags_valid = flags_valid_q;
    assign state_o     = state_q;
    assign wmask_o     = mask_q;

endmodule

// File: tb/tb_flag_gen.sv
// Bench for flag_gen: directed scenarios then random instructions, checked against
// an integer-arithmetic reference model through an expected-response queue.
module tb_flag_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         stall;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] alu_res;
    logic [W-1:0] sat_res;
    logic [2:0]   f;
    logic         flags_valid;
    logic         state_o;
    logic [2:0]   wmask_o;

    // Expected entry after each edge: {F, flags_valid, written-mask}.
    logic [6:0]   exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]   m_f;
    logic         m_valid;
    logic [2:0]   m_mask;

    flag_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .opcode(opcode),
        .A(a), .B(b), .alu_res(alu_res), .sat_res(sat_res), .F(f),
        .flags_valid(flags_valid), .state_o(state_o), .wmask_o(wmask_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed-integer view of the saturating arithmetic.
    function automatic logic [W-1:0] ref_sat(input logic [3:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y, output logic ovf);
        int sx   = $signed(x);
        int sy   = $signed(y);
        int maxv = (1 << (W - 1)) - 1;
        int minv = -(1 << (W - 1));
        int r    = (op == 4'd1) ? sx - sy : sx + sy;
        ovf = 1'b0;
        if (op > 4'd1) return W'(sx + sy);
        if (r > maxv) begin ovf = 1'b1; return W'(maxv); end
        if (r < minv) begin ovf = 1'b1; return W'(minv); end
        return W'(r);
    endfunction

    task automatic drive(input logic e, input logic s, input logic [3:0] op,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] alu);
        logic [W-1:0] exp_sat;
        logic         ovf;
        @(negedge clk);
        rst = 1'b0; en = e; stall = s; opcode = op; a = x; b = y; alu_res = alu;
        #1;
        exp_sat = ref_sat(op, x, y, ovf);
        if (op <= 4'd1) check("sat_res", sat_res, exp_sat);
        if (e && !s) begin
            if (op <= 4'd1) begin
                m_f     = {exp_sat[W-1], ovf, (exp_sat == 0)};
                m_mask  = 3'b111;
                m_valid = 1'b1;
            end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
                m_f[0]    = (alu == 0);
                m_mask[0] = 1'b1;
                m_valid   = 1'b1;
            end
        end
        exp_q.push_back({m_f, m_valid, m_mask});
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_F", {13'd0, f}, 16'd0);
        check("rst_valid", {15'd0, flags_valid}, 16'd0);
        check("rst_mask", {13'd0, wmask_o}, 16'd0);
        m_f = 3'b000; m_valid = 1'b0; m_mask = 3'b000;
        rst = 1'b0;
    endtask

    initial begin : monitor
        logic [6:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("F", {13'd0, f}, {13'd0, e[6:4]});
                check("flags_valid", {15'd0, flags_valid}, {15'd0, e[3]});
                check("wmask", {13'd0, wmask_o}, {13'd0, e[2:0]});
                check("state", {15'd0, state_o}, {15'd0, e[3]});
            end
        end
    end

    initial begin : driver
        int budget;
        rst = 1'b1; en = 1'b0; stall = 1'b0; opcode = '0; a = '0; b = '0; alu_res = '0;
        m_f = 3'b000; m_valid = 1'b0; m_mask = 3'b000;
        #2;
        check("init_F", {13'd0, f}, 16'd0);
        check("init_valid", {15'd0, flags_valid}, 16'd0);

        drive(1, 0, 4'd0, 16'h7FFF, 16'h0001, 16'h0);
        drive(1, 0, 4'd2, 16'h1234, 16'h0, 16'h0000);
        drive(1, 0, 4'd8, 16'h8000, 16'h8000, 16'h0);
        drive(1, 0, 4'd0, 16'h8000, 16'hFFFF, 16'h5);
        drive(1, 0, 4'd1, 16'h0005, 16'h0005, 16'h0);
        drive(1, 0, 4'd1, 16'h0003, 16'h0005, 16'h0);
        drive(1, 1, 4'd0, 16'h0001, 16'h0001, 16'h0);
        drive(1, 0, 4'd0, 16'h0001, 16'h0001, 16'h0);
        drive(0, 0, 4'd1, 16'h8000, 16'h0001, 16'h0);
        drive(1, 0, 4'd1, 16'h8000, 16'h0001, 16'h0);
        drive(1, 0, 4'd1, 16'h7FFF, 16'hFFFF, 16'h0);
        drive(1, 0, 4'd0, 16'h7FFF, 16'h0001, 16'h0);
        drive(1, 0, 4'd2, 16'h0, 16'h0, 16'h0000);
        drive(1, 0, 4'd3, 16'h0, 16'h0, 16'h0);
        async_reset();
        drive(1, 0, 4'd4, 16'h0, 16'h0, 16'h0001);
        drive(1, 0, 4'd0, 16'h0002, 16'h0003, 16'h0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0]   op;
            logic [W-1:0] x;
            logic [W-1:0] y;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) op = 4'($urandom_range(0, 1));
            x  = W'($urandom);
            y  = W'($urandom);
            if ($urandom_range(0, 3) == 0) y = x;
            drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0), op, x, y,
                  ($urandom_range(0, 2) == 0) ? '0 : W'($urandom));
            if (i == 200) async_reset();
        end

        @(negedge clk);
        en = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
